led_matrix_scanner: RTL and testbench

Row-scanning driver for the 8x8 LED matrix, sitting directly downstream of the 64-bit pattern source (LFSR or frame generator). It double-buffers the incoming 64-bit frame, swaps buffers only at frame boundaries so a frame is never torn, and time-multiplexes one row at a time. Each row slot has an inter-row blanking window against ghosting and 4-bit global PWM brightness.

---
 rtl/led_matrix_pkg.sv | 15 +
 rtl/led_scan_timer.sv | 38 +++
 rtl/led_matrix_scanner.sv | 102 ++++++++++
 tb/tb_led_matrix_scanner.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the 8x8 LED matrix row scanner.
package led_matrix_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  localparam logic [7:0] COL_OFF = 8'hFF;
  localparam logic [7:0] ROW_OFF = 8'h00;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } phase_t;

endpackage

// File: rtl/led_scan_timer.sv
// Row-slot timebase: tick within the slot, current row, and blank/on phase.
module led_scan_timer
  import led_matrix_pkg::*;
#(
  parameter  int unsigned ROW_TICKS   = 1024,
  parameter  int unsigned BLANK_TICKS = 16,
  localparam int unsigned TW          = $clog2(ROW_TICKS)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [TW-1:0] tick,
  output logic [2:0]    row_idx,
  output phase_t        phase,
  output logic          slot_start,
  output logic          frame_end
);

  // Free-running tick counter; row advances on each slot wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick    <= '0;
      row_idx <= '0;
    end else if (tick == TW'(ROW_TICKS - 1)) begin
      tick    <= '0;
      row_idx <= row_idx + 3'd1;
    end else begin
      tick    <= tick + TW'(1);
    end
  end

  // Phase and slot/frame markers decoded from the counters.
  always_comb begin
    phase      = (tick < TW'(BLANK_TICKS)) ? BLANK : ON;
    slot_start = (tick == '0);
    frame_end  = (tick == TW'(ROW_TICKS - 1)) && (row_idx == 3'd7);
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 LED matrix row scanner with blanking and 4-bit PWM.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROW_TICKS   = 1024,
  parameter int unsigned BLANK_TICKS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] data,
  input  logic        load,
  input  logic        oe,
  input  logic [3:0]  brightness,
  output logic [7:0]  row,
  output logic [7:0]  column,
  output logic        frame_start
);

  localparam int unsigned TW = $clog2(ROW_TICKS);

  logic [TW-1:0] tick;
  logic [2:0]    row_idx;
  phase_t        phase;
  logic          slot_start;
  logic          frame_end;

  logic [63:0]   active;
  logic [63:0]   pending;
  logic          pending_valid;
  logic [3:0]    bright_q;

  logic          lit;
  logic [7:0]    row_d;
  logic [7:0]    column_d;

  led_scan_timer #(
    .ROW_TICKS  (ROW_TICKS),
    .BLANK_TICKS(BLANK_TICKS)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .row_idx   (row_idx),
    .phase     (phase),
    .slot_start(slot_start),
    .frame_end (frame_end)
  );

  // Frame buffers: swap only at the frame boundary; a load on the swap
  // cycle lands in pending after the swap has consumed the old value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (frame_end && pending_valid) begin
        active <= pending;
      end
      if (load) begin
        pending       <= data;
        pending_valid <= 1'b1;
      end else if (frame_end) begin
        pending_valid <= 1'b0;
      end
    end
  end

  // Brightness is latched once per slot so PWM duty never changes mid-row.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bright_q <= '0;
    end else if (slot_start) begin
      bright_q <= brightness;
    end
  end

  // Next output values from the current timebase, buffer and enable.
  always_comb begin
    lit      = (phase == ON) && oe && (tick[3:0] < bright_q);
    row_d    = ROW_OFF;
    column_d = COL_OFF;
    if (lit) begin
      row_d    = 8'(1) << row_idx;
      column_d = ~active[{row_idx, 3'b000} +: COLS];
    end
  end

  // Registered outputs, one cycle behind the timebase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row         <= ROW_OFF;
      column      <= COL_OFF;
      frame_start <= 1'b0;
    end else begin
      row         <= row_d;
      column      <= column_d;
      frame_start <= slot_start && (row_idx == 3'd0);
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner (ROW_TICKS = 64, BLANK_TICKS = 4).
module tb_led_matrix_scanner;

  localparam int unsigned RT    = 64;
  localparam int unsigned BT    = 4;
  localparam int unsigned FRAME = RT * 8;
  localparam int unsigned MAXC  = 16384;

  logic        clock;
  logic        reset;
  logic [63:0] data;
  logic        load;
  logic        oe;
  logic [3:0]  brightness;
  logic [7:0]  row;
  logic [7:0]  column;
  logic        frame_start;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned c;

  // Reference model state: cycle count since reset release, load history,
  // brightness presented on every cycle.
  int unsigned ld_cyc[$];
  logic [63:0] ld_dat[$];
  logic [3:0]  br_hist[MAXC];

  led_matrix_scanner #(
    .ROW_TICKS  (RT),
    .BLANK_TICKS(BT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data       (data),
    .load       (load),
    .oe         (oe),
    .brightness (brightness),
    .row        (row),
    .column     (column),
    .frame_start(frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, obs, exp_v);
    end
  endtask

  // Expected outputs after the edge that ends cycle cc.
  task automatic check_out(input int unsigned cc, input logic oe_c);
    int unsigned t;
    int unsigned r;
    int unsigned f;
    logic [63:0] fr;
    logic [3:0]  bq;
    logic        lit;
    logic [7:0]  e_row;
    logic [7:0]  e_col;
    t  = cc % RT;
    r  = (cc / RT) % 8;
    f  = cc / FRAME;
    bq = br_hist[cc - t];
    fr = '0;
    // A load during cycle L is shown from frame (L+1)/FRAME + 1 onward; latest such wins.
    foreach (ld_cyc[i])
      if ((ld_cyc[i] + 1) / FRAME + 1 <= f) fr = ld_dat[i];
    lit   = (t >= BT) && oe_c && ((t % 16) < bq);
    e_row = lit ? 8'(1 << r) : 8'h00;
    e_col = lit ? ~fr[8*r +: 8] : 8'hFF;
    cmp("row", row, e_row);
    cmp("column", column, e_col);
    cmp("frame_start", {7'd0, frame_start}, {7'd0, (cc % FRAME) == 0});
  endtask

  task automatic tick1();
    logic oe_c;
    br_hist[c] = brightness;
    oe_c = oe;
    if (load) begin
      ld_cyc.push_back(c);
      ld_dat.push_back(data);
    end
    @(posedge clock);
    @(negedge clock);
    check_out(c, oe_c);
    c++;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick1();
  endtask

  task automatic do_load(input logic [63:0] d);
    load = 1'b1;
    data = d;
    tick1();
    load = 1'b0;
  endtask

  // Advance until the next cycle's position within the frame equals pos.
  task automatic run_to(input int unsigned pos);
    for (int unsigned i = 0; i < FRAME && (c % FRAME) != pos; i++) tick1();
  endtask

  initial begin
    logic [63:0] da, db, dc;
    n_cmp = 0;
    n_bad = 0;
    c     = 0;
    reset = 1'b1;
    load  = 1'b0;
    data  = '0;
    oe    = 1'b1;
    brightness = 4'd15;

    // Reset state
    #12;
    cmp("reset_row", row, 8'h00);
    cmp("reset_column", column, 8'hFF);
    cmp("reset_frame_start", {7'd0, frame_start}, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Idle: no load, dark columns, frame_start every FRAME cycles
    run(FRAME + 20);

    // Basic frame
    do_load(64'h0000_0000_0000_00A5);
    run(2 * FRAME);

    // PWM with all-ones frame; brightness change mid-slot
    brightness = 4'd4;
    do_load('1);
    run_to(0);
    run(FRAME);
    run_to(2 * RT + 20);
    brightness = 4'd9;
    run(FRAME);

    // Double buffer: A mid-frame, B 10 cycles later, C on the swap cycle
    brightness = 4'd15;
    da = {$urandom, $urandom};
    db = {$urandom, $urandom};
    dc = {$urandom, $urandom};
    run_to(200);
    do_load(da);
    run(9);
    do_load(db);
    run_to(FRAME - 1);
    do_load(dc);
    run(2 * FRAME + 50);

    // oe gating during row 3
    run_to(3 * RT + 10);
    oe = 1'b0;
    run(100);
    oe = 1'b1;
    run(FRAME);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        load = 1'b1;
        data = {$urandom, $urandom};
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) oe = ~oe;
      if ($urandom_range(0, 49) == 0) brightness = 4'($urandom_range(0, 15));
      tick1();
    end
    load = 1'b0;
    oe   = 1'b1;
    brightness = 4'd15;

    // Async reset mid-frame while row 5 is lit
    do_load('1);
    run_to(0);
    run(FRAME);
    run_to(5 * RT + 30);
    cmp("pre_reset_row", row, 8'h20);
    #2 reset = 1'b1;
    #1;
    cmp("async_reset_row", row, 8'h00);
    cmp("async_reset_column", column, 8'hFF);
    cmp("async_reset_frame_start", {7'd0, frame_start}, 8'h00);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    c = 0;
    ld_cyc.delete();
    ld_dat.delete();
    run(FRAME + 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
